lector_d_fifos: RTL and testbench
=================================

// Module: lector_d_fifos
// PURPOSE
//  Receive-side counterpart of the transmit full-logic chain: pops the two destination FIFOs (D0, D1).
//  Round-robin arbitration with a programmable burst limit.
//  Merges both streams into one valid/ready output tagged with source id; reports idle/active/error like the main FSM.
// PARAMETERS
//  data_width   6  word width of D0/D1 FIFO data and of data_out
//  count_width  8  width of per-destination word counters (WORD_COUNT_EN only)
// PORTS
//  clk           in   1           single clock, all state on rising edge
//  reset         in   1           asynchronous, active-low reset
//  init          in   1           1 = run; 0 = configuration (capture umbral_burst)
//  umbral_burst  in   4           max consecutive pops from one FIFO while the other is non-empty
//  data_in_D0    in   data_width  D0 FIFO read data, valid the cycle after D0_pop
//  data_in_D1    in   data_width  D1 FIFO read data, valid the cycle after D1_pop
//  empty_D0      in   1           D0 FIFO empty
//  empty_D1      in   1           D1 FIFO empty
//  sink_ready    in   1           downstream accepts data_out this cycle
//  D0_pop        out  1           pop D0 (combinational from registered state + inputs)
//  D1_pop        out  1           pop D1
//  data_out      out  data_width  head word of the 2-entry output buffer
//  valid_out     out  1           data_out valid; transfer when valid_out & sink_ready
//  src_out       out  1           0 = word came from D0, 1 = from D1
//  idle_out      out  1           FSM in IDLE
//  active_out    out  1           FSM in ACTIVE
//  error_out     out  1           FSM in ERROR (sticky)
//  count_D0      out  count_width words delivered from D0 (WORD_COUNT_EN only)
//  count_D1      out  count_width words delivered from D1 (WORD_COUNT_EN only)
// BEHAVIOUR
//  - Reset (reset=0, async): state=RESET; all outputs 0; buffer empty; pending=0; burst_cnt=0; last_src=1 (D0 wins first).
//  - FSM:
//    - RESET -> INIT on the first clk after reset release.
//    - INIT: umbral_reg <= umbral_burst every cycle. On init=1: umbral_reg==0 -> ERROR, else -> IDLE.
//    - IDLE: both empty, no pending read, buffer empty. Any empty_Dx=0 -> ACTIVE.
//    - ACTIVE -> IDLE when both empty, pending=0 and buffer empty.
//    - init=0 in IDLE/ACTIVE -> INIT next cycle: pops stop at once; pending word still captured; buffer keeps draining.
//    - ERROR: no pops; buffer drains; exit only via reset.
//  - Read latency 1: pop in cycle N -> data_in_Dx sampled at end of cycle N+1 -> in buffer, visible from N+2.
//    pending flag and pend_src track the outstanding read.
//  - Pop allowed only in ACTIVE/IDLE with init=1, and only if (buffer occupancy after this cycle's dequeue) + pending < 2.
//    Gives 1 word/cycle sustained with sink_ready=1. At most one pop per cycle; never pop an FIFO with empty=1.
//  - Arbitration:
//    - Stay on cur_src while its FIFO is non-empty and burst_cnt < umbral_reg.
//    - Switch when cur empty, or burst_cnt==umbral_reg and the other FIFO is non-empty.
//    - burst_cnt resets to 1 on switch, increments (saturating at 15) on each same-source pop.
//    - Only one FIFO non-empty -> pop it every eligible cycle regardless of limit.
//    - Both non-empty from rest -> the source opposite last_src wins.
//  - Output buffer: 2-entry FIFO of {src,data}.
//    - Simultaneous capture and dequeue on a full buffer is legal; occupancy unchanged.
//    - data_out/src_out hold stable while valid_out=1 & sink_ready=0.
//  - umbral_burst changes while init=1 are ignored.
// CONFIGURATION
//  - WORD_COUNT_EN defined: count_D0/count_D1 increment on each output transfer of their source.
//    Wrap modulo 2^count_width; cleared by reset only.
//  - WORD_COUNT_EN undefined: count ports and counters are absent.
// TESTING
//  1. Reset low mid-burst -> next delta all outputs 0, pops 0; after release + init=1, umbral=2 -> idle_out=1.
//  2. umbral=2, D0 holds 5 words, D1 holds 5, sink_ready=1 -> src_out order 0,0,1,1,0,0,1,1,0,1; one word/cycle after 2-cycle latency.
//  3. Only D1 non-empty (4 words), umbral=1 -> D1_pop high 4 consecutive cycles, D0_pop never high.
//  4. sink_ready=0 with D0 holding 6 words -> exactly 2 pops, valid_out=1, data_out stable; release -> remaining 4 words in order, none lost or duplicated.
//  5. init=1 with umbral_burst=0 -> error_out=1 next cycle, no pops even with empty_D0=0; only reset clears error_out.
//  6. WORD_COUNT_EN: deliver 3 D0 + 7 D1 words -> count_D0=3, count_D1=7; 256 D0 words with count_width=8 -> count_D0 wraps to 0.

Source files
------------

// File: rtl/lector_d_fifos.sv
// Receive-side reader for the two destination FIFOs: round-robin arbitration with a burst limit, merged into one tagged valid/ready stream.
// Optional per-source delivered-word counters are built when WORD_COUNT_EN is defined.
module lector_d_fifos #(
    parameter int data_width  = 6,
    parameter int count_width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic [3:0]             umbral_burst,
    input  logic [data_width-1:0]  data_in_D0,
    input  logic [data_width-1:0]  data_in_D1,
    input  logic                   empty_D0,
    input  logic                   empty_D1,
    input  logic                   sink_ready,
    output logic                   D0_pop,
    output logic                   D1_pop,
    output logic [data_width-1:0]  data_out,
    output logic                   valid_out,
    output logic                   src_out,
    output logic                   idle_out,
    output logic                   active_out,
`ifdef WORD_COUNT_EN
    output logic                   error_out,
    output logic [count_width-1:0] count_D0,
    output logic [count_width-1:0] count_D1
`else
    output logic                   error_out
`endif
);

    typedef enum logic [2:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;

    state_t                state, state_next;
    logic [3:0]            umbral_reg;
    logic [3:0]            burst_cnt;
    logic                  last_src;
    logic                  pending;
    logic                  pend_src;
    logic [data_width:0]   buf0, buf1;
    logic [1:0]            occ;

    logic                  ne0, ne1, cur_ne, other_ne;
    logic                  deq, can_pop, do_pop, sel;
    logic [1:0]            occ_after;
    logic [data_width:0]   cap_word;

    assign ne0       = ~empty_D0;
    assign ne1       = ~empty_D1;
    assign cur_ne    = last_src ? ne1 : ne0;
    assign other_ne  = last_src ? ne0 : ne1;
    assign valid_out = (occ != 2'd0);
    assign deq       = valid_out & sink_ready;
    assign occ_after = occ - {1'b0, deq};
    assign cap_word  = {pend_src, pend_src ? data_in_D1 : data_in_D0};

    // A pop is issued only when the word it returns is guaranteed a buffer slot.
    assign can_pop = ((state == ST_IDLE) || (state == ST_ACTIVE)) && init
                     && ((occ_after + {1'b0, pending}) < 2'd2);
    assign do_pop  = can_pop & (ne0 | ne1);
    assign D0_pop  = do_pop & ~sel;
    assign D1_pop  = do_pop & sel;

    // burst_cnt==0 only before the first pop, where the source opposite last_src starts.
    always_comb begin
        sel = last_src;
        if ((burst_cnt == 4'd0) && ne0 && ne1)
            sel = ~last_src;
        else if (cur_ne && ((burst_cnt < umbral_reg) || !other_ne))
            sel = last_src;
        else
            sel = ~last_src;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET:  state_next = ST_INIT;
            ST_INIT:   if (init) state_next = (umbral_reg == 4'd0) ? ST_ERROR : ST_IDLE;
            ST_IDLE:   if (!init) state_next = ST_INIT;
                       else if (ne0 || ne1) state_next = ST_ACTIVE;
            ST_ACTIVE: if (!init) state_next = ST_INIT;
                       else if (!ne0 && !ne1 && !pending && (occ == 2'd0)) state_next = ST_IDLE;
            ST_ERROR:  state_next = ST_ERROR;
            default:   state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RESET;
            umbral_reg <= 4'd0;
            burst_cnt  <= 4'd0;
            last_src   <= 1'b1;
            pending    <= 1'b0;
            pend_src   <= 1'b0;
        end else begin
            state    <= state_next;
            pending  <= do_pop;
            pend_src <= sel;
            if (state == ST_INIT)
                umbral_reg <= umbral_burst;
            if (do_pop) begin
                if (sel == last_src) begin
                    if (burst_cnt != 4'hF)
                        burst_cnt <= burst_cnt + 4'd1;
                end else begin
                    burst_cnt <= 4'd1;
                    last_src  <= sel;
                end
            end
        end
    end

    // Two-entry buffer kept head-aligned in buf0 so data_out never moves during a stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf0 <= '0;
            buf1 <= '0;
            occ  <= 2'd0;
        end else begin
            case ({pending, deq})
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) buf0 <= cap_word;
                    else             buf1 <= cap_word;
                    occ <= occ + 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= cap_word;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= cap_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out   = buf0[data_width-1:0];
    assign src_out    = buf0[data_width];
    assign idle_out   = (state == ST_IDLE);
    assign active_out = (state == ST_ACTIVE);
    assign error_out  = (state == ST_ERROR);

`ifdef WORD_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_D0 <= '0;
            count_D1 <= '0;
        end else if (deq) begin
            if (src_out) count_D1 <= count_D1 + 1'b1;
            else         count_D0 <= count_D0 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lector_d_fifos.sv
// Bench for lector_d_fifos: FIFO environment plus a queue-based reference model compared every cycle, directed scenarios and random traffic.
// Build with WORD_COUNT_EN defined to also exercise the delivered-word counters.
module tb_lector_d_fifos;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [3:0]    umbral_burst;
    logic [DW-1:0] data_in_D0, data_in_D1;
    logic          empty_D0, empty_D1, sink_ready;
    logic          D0_pop, D1_pop;
    logic [DW-1:0] data_out;
    logic          valid_out, src_out, idle_out, active_out, error_out;
`ifdef WORD_COUNT_EN
    logic [CW-1:0] count_D0, count_D1;
`endif

    always #5 clk = ~clk;

    lector_d_fifos #(.data_width(DW), .count_width(CW)) dut (
        .clk(clk), .reset(reset), .init(init), .umbral_burst(umbral_burst),
        .data_in_D0(data_in_D0), .data_in_D1(data_in_D1),
        .empty_D0(empty_D0), .empty_D1(empty_D1), .sink_ready(sink_ready),
        .D0_pop(D0_pop), .D1_pop(D1_pop), .data_out(data_out), .valid_out(valid_out),
        .src_out(src_out), .idle_out(idle_out), .active_out(active_out),
`ifdef WORD_COUNT_EN
        .error_out(error_out), .count_D0(count_D0), .count_D1(count_D1)
`else
        .error_out(error_out)
`endif
    );

    typedef enum {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} mstate_t;

    logic [DW-1:0] q0[$], q1[$];
    mstate_t       m_state;
    int            m_umbral, m_burst, m_cnt0, m_cnt1;
    bit            m_last, m_pend, m_pend_src;
    logic [DW-1:0] m_pend_word;
    logic [DW:0]   m_outq[$];

    int            vectors, miscompares, cyc;
    bit            pop0_s, pop1_s;
    int            pop0_n, pop1_n, pop1_first, pop1_last;
    int            xfer_src[$], xfer_cyc[$];
    logic [DW-1:0] xfer_data[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        pop0_n = 0; pop1_n = 0; pop1_first = -1; pop1_last = -1;
        xfer_src.delete(); xfer_cyc.delete(); xfer_data.delete();
    endtask

    task automatic push_word(input bit src, input logic [DW-1:0] w);
        if (src) q1.push_back(w); else q0.push_back(w);
        empty_D0 = (q0.size() == 0);
        empty_D1 = (q1.size() == 0);
    endtask

    // Per-cycle comparison against the model, then the model advances past the coming edge.
    task automatic check_cycle();
        bit ne0, ne1, deq, allowed, room, do_pop, sel;
        mstate_t nstate;
        logic [DW:0] w;
        ne0 = q0.size() > 0;
        ne1 = q1.size() > 0;
        pop0_s = D0_pop;
        pop1_s = D1_pop;
        if (D0_pop) pop0_n++;
        if (D1_pop) begin
            if (pop1_n == 0) pop1_first = cyc;
            pop1_last = cyc;
            pop1_n++;
        end
        if (valid_out && sink_ready) begin
            xfer_src.push_back(int'(src_out));
            xfer_data.push_back(data_out);
            xfer_cyc.push_back(cyc);
        end
        if (!reset) begin
            check_output("pop_in_reset", 32'({D1_pop, D0_pop}), 32'd0);
            check_output("valid_in_reset", 32'(valid_out), 32'd0);
            check_output("flags_in_reset", 32'({idle_out, active_out, error_out}), 32'd0);
        end else begin
            deq     = (m_outq.size() > 0) && sink_ready;
            allowed = ((m_state == M_IDLE) || (m_state == M_ACTIVE)) && init;
            room    = (m_outq.size() - int'(deq) + int'(m_pend)) < 2;
            do_pop  = allowed && room && (ne0 || ne1);
            if (ne0 && ne1) sel = (m_burst == 0 || m_burst >= m_umbral) ? !m_last : m_last;
            else            sel = ne1;

            check_output("D0_pop", 32'(D0_pop), 32'(do_pop && !sel));
            check_output("D1_pop", 32'(D1_pop), 32'(do_pop && sel));
            check_output("valid_out", 32'(valid_out), 32'(m_outq.size() > 0));
            if (m_outq.size() > 0) begin
                check_output("data_out", 32'(data_out), 32'(m_outq[0][DW-1:0]));
                check_output("src_out", 32'(src_out), 32'(m_outq[0][DW]));
            end
            check_output("idle_out", 32'(idle_out), 32'(m_state == M_IDLE));
            check_output("active_out", 32'(active_out), 32'(m_state == M_ACTIVE));
            check_output("error_out", 32'(error_out), 32'(m_state == M_ERROR));
`ifdef WORD_COUNT_EN
            check_output("count_D0", 32'(count_D0), 32'(m_cnt0 % (1 << CW)));
            check_output("count_D1", 32'(count_D1), 32'(m_cnt1 % (1 << CW)));
`endif
            nstate = m_state;
            case (m_state)
                M_RESET:  nstate = M_INIT;
                M_INIT:   if (init) nstate = (m_umbral == 0) ? M_ERROR : M_IDLE;
                M_IDLE:   if (!init) nstate = M_INIT; else if (ne0 || ne1) nstate = M_ACTIVE;
                M_ACTIVE: if (!init) nstate = M_INIT;
                          else if (!ne0 && !ne1 && !m_pend && m_outq.size() == 0) nstate = M_IDLE;
                default:  ;
            endcase
            if (deq) begin
                w = m_outq.pop_front();
                if (w[DW]) m_cnt1++; else m_cnt0++;
            end
            if (m_pend) m_outq.push_back({m_pend_src, m_pend_word});
            if (do_pop) begin
                m_pend_word = sel ? q1[0] : q0[0];
                if (sel == m_last) m_burst = (m_burst < 15) ? m_burst + 1 : 15;
                else begin
                    m_burst = 1;
                    m_last  = sel;
                end
            end
            m_pend     = do_pop;
            m_pend_src = sel;
            if (m_state == M_INIT) m_umbral = int'(umbral_burst);
            m_state = nstate;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (pop0_s && q0.size() > 0) data_in_D0 = q0.pop_front();
        if (pop1_s && q1.size() > 0) data_in_D1 = q1.pop_front();
        empty_D0 = (q0.size() == 0);
        empty_D1 = (q1.size() == 0);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_output("rst_pops", 32'({D1_pop, D0_pop}), 32'd0);
        check_output("rst_data_out", 32'(data_out), 32'd0);
        check_output("rst_valid_src", 32'({valid_out, src_out}), 32'd0);
        check_output("rst_flags", 32'({idle_out, active_out, error_out}), 32'd0);
`ifdef WORD_COUNT_EN
        check_output("rst_counts", 32'({count_D1, count_D0}), 32'd0);
`endif
        m_state = M_RESET; m_umbral = 0; m_burst = 0; m_last = 1'b1;
        m_pend = 1'b0; m_pend_src = 1'b0; m_pend_word = '0; m_outq.delete();
        m_cnt0 = 0; m_cnt1 = 0;
        q0.delete(); q1.delete();
        empty_D0 = 1'b1; empty_D1 = 1'b1;
        data_in_D0 = '0; data_in_D1 = '0;
        init = 1'b0; sink_ready = 1'b0;
        pop0_s = 1'b0; pop1_s = 1'b0;
        run(2);
        reset = 1'b1;
    endtask

    task automatic configure(input logic [3:0] u);
        init = 1'b0;
        umbral_burst = u;
        run(2);
        init = 1'b1;
        step();
    endtask

    task automatic apply_stimulus(input int n);
        int init_hold;
        init_hold = 0;
        for (int i = 0; i < n; i++) begin
            sink_ready = ($urandom_range(0, 3) != 0);
            if (q0.size() < 8 && $urandom_range(0, 2) == 0) push_word(1'b0, DW'($urandom));
            if (q1.size() < 8 && $urandom_range(0, 2) == 0) push_word(1'b1, DW'($urandom));
            if (init && $urandom_range(0, 149) == 0) begin
                init = 1'b0;
                umbral_burst = 4'($urandom_range(1, 15));
            end else if (!init && $urandom_range(0, 3) == 0) begin
                init = 1'b1;
                init_hold = 0;
            end else if (init && init_hold > 2 && $urandom_range(0, 19) == 0) begin
                umbral_burst = 4'($urandom_range(0, 15));
            end
            if (init) init_hold++;
            step();
        end
    endtask

    initial begin
        int exp_src[10];
        int c0;
        exp_src = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1};
        vectors = 0; miscompares = 0; cyc = 0;
        umbral_burst = 4'd0;
        clear_logs();
        do_reset();

        // Alternating bursts of two with both FIFOs loaded.
        configure(4'd2);
        check_output("t2_idle", 32'(idle_out), 32'd1);
        sink_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_word(1'b0, DW'(8'h10 + i));
            push_word(1'b1, DW'(8'h20 + i));
        end
        clear_logs();
        c0 = cyc;
        run(16);
        check_output("t2_xfer_count", 32'(xfer_src.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            check_output("t2_src_order", (i < xfer_src.size()) ? 32'(xfer_src[i]) : 32'hBAD, 32'(exp_src[i]));
        check_output("t2_first_cycle", (xfer_cyc.size() > 0) ? 32'(xfer_cyc[0]) : 32'hBAD, 32'(c0 + 2));
        check_output("t2_last_cycle", (xfer_cyc.size() == 10) ? 32'(xfer_cyc[9]) : 32'hBAD, 32'(c0 + 11));
        check_output("t2_first_data", (xfer_data.size() > 0) ? 32'(xfer_data[0]) : 32'hBAD, 32'h10);

        // Reset asserted in the middle of a burst, then reconfigure.
        for (int i = 0; i < 4; i++) begin
            push_word(1'b0, DW'(i));
            push_word(1'b1, DW'(i + 4));
        end
        run(3);
        do_reset();
        configure(4'd2);
        check_output("t1_idle_after_init", 32'(idle_out), 32'd1);

        // Only D1 loaded with a burst limit of one.
        do_reset();
        configure(4'd1);
        sink_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(1'b1, DW'(8'h28 + i));
        clear_logs();
        run(10);
        check_output("t3_d1_pops", 32'(pop1_n), 32'd4);
        check_output("t3_d0_pops", 32'(pop0_n), 32'd0);
        check_output("t3_d1_span", 32'(pop1_last - pop1_first), 32'd3);

        // Back-pressure with six D0 words, then release.
        do_reset();
        configure(4'd3);
        sink_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(1'b0, DW'(8'h30 + i));
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            step();
            if (i >= 2) begin
                check_output("t4_hold_valid", 32'(valid_out), 32'd1);
                check_output("t4_hold_data", 32'(data_out), 32'h30);
            end
        end
        check_output("t4_stall_pops", 32'(pop0_n), 32'd2);
        sink_ready = 1'b1;
        clear_logs();
        run(12);
        check_output("t4_xfer_count", 32'(xfer_data.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check_output("t4_order", (i < xfer_data.size()) ? 32'(xfer_data[i]) : 32'hBAD, 32'(8'h30 + i));

        // Zero burst limit locks the block in ERROR until reset.
        do_reset();
        init = 1'b0;
        umbral_burst = 4'd0;
        run(2);
        init = 1'b1;
        push_word(1'b0, DW'(8'h3A));
        step();
        check_output("t5_error_set", 32'(error_out), 32'd1);
        clear_logs();
        run(5);
        init = 1'b0;
        run(2);
        check_output("t5_no_pops", 32'(pop0_n + pop1_n), 32'd0);
        check_output("t5_error_sticky", 32'(error_out), 32'd1);
        do_reset();
        check_output("t5_error_cleared", 32'(error_out), 32'd0);

`ifdef WORD_COUNT_EN
        configure(4'd3);
        sink_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(1'b0, DW'(i));
        for (int i = 0; i < 7; i++) push_word(1'b1, DW'(i));
        run(20);
        check_output("t6_count_D0", 32'(count_D0), 32'd3);
        check_output("t6_count_D1", 32'(count_D1), 32'd7);
        for (int i = 0; i < 253; i++) push_word(1'b0, DW'(i));
        run(300);
        check_output("t6_count_D0_wrap", 32'(count_D0), 32'd0);
        do_reset();
`endif

        // Random traffic, back-pressure and reconfiguration.
        configure(4'($urandom_range(1, 15)));
        apply_stimulus(2000);
        init = 1'b1;
        sink_ready = 1'b1;
        run(60);
        check_output("rand_drained", 32'(q0.size() + q1.size() + m_outq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
